// File: rtl/mprj_checkpoint_monitor_if.sv
// Control/status bundle for the checkpoint monitor: table programming, arm,
// observed checkpoint bus and the pass/fail results.
interface mprj_checkpoint_monitor_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
);
  localparam int AW = $clog2(DEPTH);
  localparam int IW = $clog2(DEPTH + 1);

  logic             start;
  logic [IW-1:0]    seq_len;
  logic             exp_we;
  logic [AW-1:0]    exp_addr;
  logic [WIDTH-1:0] exp_data;
  logic [WIDTH-1:0] checkbits_i;
  logic             busy;
  logic             pass;
  logic             fail;
  logic [1:0]       fail_code;
  logic [IW-1:0]    match_idx;
  logic [WIDTH-1:0] last_value;

  modport master (
    output start, seq_len, exp_we, exp_addr, exp_data, checkbits_i,
    input  busy, pass, fail, fail_code, match_idx, last_value
  );

  modport slave (
    input  start, seq_len, exp_we, exp_addr, exp_data, checkbits_i,
    output busy, pass, fail, fail_code, match_idx, last_value
  );
endinterface

// File: rtl/mprj_checkpoint_monitor.sv
// Checkpoint sequencer: glitch-filters a GPIO checkpoint bus and matches the
// qualified values against an ordered table, with per-step timeout.
module mprj_checkpoint_monitor #(
  parameter int WIDTH          = 16,
  parameter int DEPTH          = 4,
  parameter int STABLE_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 700000,
  parameter bit STRICT         = 1'b0
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  mprj_checkpoint_monitor_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int IW = $clog2(DEPTH + 1);
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_DONE} state_e;
  typedef enum logic [1:0] {
    FC_NONE    = 2'd0,
    FC_TIMEOUT = 2'd1,
    FC_STRICT  = 2'd2
  } fail_code_e;

  logic [WIDTH-1:0] r_table [DEPTH];

  logic [WIDTH-1:0] r_prev;
  logic [CW-1:0]    r_run_cnt;
  logic             r_qual;
  logic [WIDTH-1:0] r_last_value;

  state_e           r_state,     w_state_nxt;
  logic [TW-1:0]    r_timer,     w_timer_nxt;
  logic [IW-1:0]    r_match_idx, w_match_idx_nxt;
  logic             r_pass,      w_pass_nxt;
  logic             r_fail,      w_fail_nxt;
  fail_code_e       r_fail_code, w_fail_code_nxt;
  logic [IW-1:0]    r_seq_len;
  logic [WIDTH-1:0] r_baseline;

  logic             w_start_acc;
  logic             w_same;
  logic [CW-1:0]    w_run_cnt_nxt;
  logic             w_qual_nxt;
  logic [IW-1:0]    w_seq_len_clamp;
  logic [IW-1:0]    w_match_idx_inc;
  logic [AW-1:0]    w_cur_idx;
  logic [AW-1:0]    w_prev_idx;
  logic [WIDTH-1:0] w_exp_cur;
  logic [WIDTH-1:0] w_ref;
  logic             w_match;
  logic             w_strict_fail;
  logic             w_timeout;

  assign w_start_acc = bus.start && (r_state != S_ARMED);

  // NOTE: the table is a register array rather than a RAM macro, so it can be cleared by reset.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      for (int i = 0; i < DEPTH; i++) r_table[i] <= '0;
    end else if (bus.exp_we && (r_state != S_ARMED)) begin
      r_table[bus.exp_addr] <= bus.exp_data;
    end
  end

  // Glitch filter: a run qualifies once, on the cycle its length reaches STABLE_CYCLES.
  assign w_same = (bus.checkbits_i == r_prev);

  always_comb begin
    w_run_cnt_nxt = r_run_cnt;
    if (w_start_acc)                             w_run_cnt_nxt = '0;
    else if (!w_same)                            w_run_cnt_nxt = CW'(1);
    else if (r_run_cnt != CW'(STABLE_CYCLES))    w_run_cnt_nxt = r_run_cnt + 1'b1;
  end

  assign w_qual_nxt = !w_start_acc && (w_run_cnt_nxt == CW'(STABLE_CYCLES)) &&
                      (!w_same || (r_run_cnt != CW'(STABLE_CYCLES)));

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_prev       <= '0;
      r_run_cnt    <= '0;
      r_qual       <= 1'b0;
      r_last_value <= '0;
    end else begin
      r_prev    <= bus.checkbits_i;
      r_run_cnt <= w_run_cnt_nxt;
      r_qual    <= w_qual_nxt;
      if (w_qual_nxt) r_last_value <= bus.checkbits_i;
    end
  end

  assign w_seq_len_clamp = (bus.seq_len > IW'(DEPTH)) ? IW'(DEPTH) : bus.seq_len;
  assign w_match_idx_inc = r_match_idx + 1'b1;
  assign w_cur_idx       = r_match_idx[AW-1:0];
  assign w_prev_idx      = w_cur_idx - 1'b1;
  assign w_exp_cur       = r_table[w_cur_idx];
  assign w_ref           = (r_match_idx == '0) ? r_baseline : r_table[w_prev_idx];

  // Staying on the previous step's value (or the arm-time bus) is never a strict violation.
  assign w_match       = r_qual && (r_last_value == w_exp_cur);
  assign w_strict_fail = STRICT && r_qual && (r_last_value != w_exp_cur) &&
                         (r_last_value != w_ref);
  assign w_timeout     = (r_timer == TW'(TIMEOUT_CYCLES - 1));

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt     = r_state;
    w_timer_nxt     = r_timer;
    w_match_idx_nxt = r_match_idx;
    w_pass_nxt      = r_pass;
    w_fail_nxt      = r_fail;
    w_fail_code_nxt = r_fail_code;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_start_acc) begin
          w_state_nxt     = S_ARMED;
          w_timer_nxt     = '0;
          w_match_idx_nxt = '0;
          w_pass_nxt      = 1'b0;
          w_fail_nxt      = 1'b0;
          w_fail_code_nxt = FC_NONE;
        end
      end
      S_ARMED: begin
        w_timer_nxt = r_timer + 1'b1;
        if (r_seq_len == '0) begin
          w_state_nxt = S_DONE;
          w_pass_nxt  = 1'b1;
        end else if (w_match) begin
          w_match_idx_nxt = w_match_idx_inc;
          w_timer_nxt     = '0;
          if (w_match_idx_inc == r_seq_len) begin
            w_state_nxt = S_DONE;
            w_pass_nxt  = 1'b1;
          end
        end else if (w_strict_fail) begin
          w_state_nxt     = S_DONE;
          w_fail_nxt      = 1'b1;
          w_fail_code_nxt = FC_STRICT;
        end else if (w_timeout) begin
          w_state_nxt     = S_DONE;
          w_fail_nxt      = 1'b1;
          w_fail_code_nxt = FC_TIMEOUT;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state     <= S_IDLE;
      r_timer     <= '0;
      r_match_idx <= '0;
      r_pass      <= 1'b0;
      r_fail      <= 1'b0;
      r_fail_code <= FC_NONE;
      r_seq_len   <= '0;
      r_baseline  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_timer     <= w_timer_nxt;
      r_match_idx <= w_match_idx_nxt;
      r_pass      <= w_pass_nxt;
      r_fail      <= w_fail_nxt;
      r_fail_code <= w_fail_code_nxt;
      if (w_start_acc) begin
        r_seq_len  <= w_seq_len_clamp;
        r_baseline <= bus.checkbits_i;
      end
    end
  end

  assign bus.busy       = (r_state == S_ARMED);
  assign bus.pass       = r_pass;
  assign bus.fail       = r_fail;
  assign bus.fail_code  = r_fail_code;
  assign bus.match_idx  = r_match_idx;
  assign bus.last_value = r_last_value;
endmodule
